encoder8to3_arb: RTL and testbench

//  Sequential 8-to-3 priority encoder; the inverse of decoder3to8.
//  - Collects one-hot or multi-hot request pulses into a sticky pending register.
//  - Emits one 3-bit code per grant over a valid/ready handshake.
//  - Drains every captured request in priority order.
//  - Sits in front of the decoder path, so a loopback encoder->decoder reproduces the original request bits.

---
 rtl/encoder8to3_arb_pkg.sv | 20 ++
 rtl/encoder8to3_arb_if.sv | 31 +++
 rtl/encoder8to3_arb_prio_sel8.sv | 29 ++
 rtl/encoder8to3_arb.sv | 98 +++++++++
 tb/tb_encoder8to3_arb.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/encoder8to3_arb_pkg.sv
// Shared types for the 8-to-3 request encoder and its priority selector.
//   N_IN / CODE_W : request line count and matching code width
//   code_t/req_t  : encoded index and request-vector types
//   enc_state_t   : output FSM states (IDLE: no code presented, HOLD: code presented)
//   code2oh       : code -> one-hot expansion (the decoder3to8 function)
package encoder8to3_arb_pkg;

  localparam int N_IN   = 8;
  localparam int CODE_W = $clog2(N_IN);

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [N_IN-1:0]   req_t;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} enc_state_t;

  function automatic req_t code2oh(code_t c);
    return req_t'(1) << c;
  endfunction

endpackage

// File: rtl/encoder8to3_arb_if.sv
// Request/grant bus of the encoder.
//   clr        : synchronous flush
//   in_req     : request pulses, sampled every cycle
//   out_code   : granted index, out_onehot its one-hot form
//   out_valid  : code presented, out_ready : consumer accept
//   pend       : captured but not yet granted requests
//   drop       : a request merged into an already-pending or presented bit
// slave = encoder side, master = requester/consumer side.
interface encoder8to3_arb_if;
  import encoder8to3_arb_pkg::*;

  logic  clr;
  req_t  in_req;
  logic  out_ready;
  code_t out_code;
  req_t  out_onehot;
  logic  out_valid;
  req_t  pend;
  logic  drop;

  modport slave (
    input  clr, in_req, out_ready,
    output out_code, out_onehot, out_valid, pend, drop
  );

  modport master (
    output clr, in_req, out_ready,
    input  out_code, out_onehot, out_valid, pend, drop
  );

endinterface

// File: rtl/encoder8to3_arb_prio_sel8.sv
// Combinational 8-way priority selector.
//   vec : candidate request vector
//   idx : index of the winning bit (0 when vec is empty)
//   any : vec has at least one bit set
// HI_FIRST=1 picks the highest set index, HI_FIRST=0 the lowest.
module encoder8to3_arb_prio_sel8
  import encoder8to3_arb_pkg::*;
#(
  parameter bit HI_FIRST = 1'b1
) (
  input  req_t  vec,
  output code_t idx,
  output logic  any
);

  // Scan toward the winning end; the last hit seen is the winner.
  always_comb begin
    idx = '0;
    any = |vec;
    if (HI_FIRST) begin
      for (int i = 0; i < N_IN; i++)
        if (vec[i]) idx = code_t'(i);
    end else begin
      for (int i = N_IN-1; i >= 0; i--)
        if (vec[i]) idx = code_t'(i);
    end
  end

endmodule

// File: rtl/encoder8to3_arb.sv
// Sequential 8-to-3 priority encoder with sticky pending requests.
// Requests are captured into pend and drained one code per accepted
// valid/ready transfer, in priority order.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : encoder8to3_arb_if.slave (requests in, codes out)
// HI_FIRST selects the priority direction (1: bit 7 wins).
module encoder8to3_arb
  import encoder8to3_arb_pkg::*;
#(
  parameter bit HI_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  encoder8to3_arb_if.slave          bus
);

  enc_state_t state;
  req_t       pend_q;
  req_t       oh_q;
  code_t      code_q;
  logic       valid_q;
  logic       drop_q;

  logic  acc;
  req_t  cand;
  code_t sel;
  logic  any;
  req_t  sel_oh;
  logic  load;
  req_t  held;
  req_t  pend_d;
  logic  drop_d;

  assign acc  = valid_q & bus.out_ready;
  // Bypass: a request can be granted in the cycle it arrives.
  assign cand = pend_q | bus.in_req;

  encoder8to3_arb_prio_sel8 #(.HI_FIRST(HI_FIRST)) u_sel (
    .vec (cand),
    .idx (sel),
    .any (any)
  );

  assign sel_oh = code2oh(sel);
  // The output slot is free when nothing is presented or it is leaving now.
  assign load   = any & ((state == IDLE) | acc);
  // Bit presented and stalled: a repeat request for it is already covered.
  assign held   = (valid_q & ~acc) ? oh_q : '0;

  always_comb begin
    pend_d = pend_q | (bus.in_req & ~held);
    drop_d = |(bus.in_req & (pend_q | held));
    if (load) begin
      // A fresh request on a bit granted out of pend re-arms it (set wins
      // over clear); a bit granted straight from in_req is consumed.
      pend_d = (cand & ~sel_oh) | (bus.in_req & pend_q & sel_oh);
      drop_d = |(bus.in_req & pend_q & ~sel_oh);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pend_q  <= '0;
      oh_q    <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else if (bus.clr) begin
      state   <= IDLE;
      pend_q  <= '0;
      oh_q    <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      drop_q <= drop_d;
      if (load) begin
        state   <= HOLD;
        valid_q <= 1'b1;
        code_q  <= sel;
        oh_q    <= sel_oh;
      end else if (acc) begin
        state   <= IDLE;
        valid_q <= 1'b0;
        oh_q    <= '0;
      end
    end
  end

  assign bus.out_code   = code_q;
  assign bus.out_onehot = oh_q;
  assign bus.out_valid  = valid_q;
  assign bus.pend       = pend_q;
  assign bus.drop       = drop_q;

endmodule

// File: tb/tb_encoder8to3_arb.sv
// Bench for encoder8to3_arb: two instances (HI_FIRST=1 and 0) driven with the
// same stimulus, each compared every cycle against a per-bit request model,
// plus directed scenarios with constant expectations.
module tb_encoder8to3_arb;
  import encoder8to3_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  encoder8to3_arb_if bus_h ();
  encoder8to3_arb_if bus_l ();

  encoder8to3_arb #(.HI_FIRST(1'b1)) dut_h (.clk(clk), .rst_n(rst_n), .bus(bus_h.slave));
  encoder8to3_arb #(.HI_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l.slave));

  int n_chk  = 0;
  int n_pass = 0;

  // model state, index 0: HI_FIRST=1, index 1: HI_FIRST=0
  req_t  m_pend  [2];
  logic  m_valid [2];
  code_t m_code  [2];
  logic  m_drop  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic int pick(req_t v, bit hi);
    if (hi) begin
      for (int i = N_IN-1; i >= 0; i--) if (v[i]) return i;
    end else begin
      for (int i = 0; i < N_IN; i++) if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = '0; m_valid[k] = 1'b0; m_code[k] = '0; m_drop[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input req_t req, input logic rdy, input logic c);
    logic acc, stalled;
    req_t cand, np;
    int   s;
    logic d;
    if (c) begin
      m_pend[k] = '0; m_valid[k] = 1'b0; m_code[k] = '0; m_drop[k] = 1'b0;
      return;
    end
    acc     = m_valid[k] && rdy;
    stalled = m_valid[k] && !rdy;
    cand    = m_pend[k] | req;
    s       = stalled ? -1 : pick(cand, k == 0);
    np      = m_pend[k];
    d       = 1'b0;
    if (s >= 0) np[s] = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (!req[i]) continue;
      if (i == s) begin
        if (m_pend[k][i]) np[i] = 1'b1;       // new request behind the granted one
      end else if (m_pend[k][i]) d = 1'b1;     // already waiting
      else if (stalled && int'(m_code[k]) == i) d = 1'b1;  // already presented
      else np[i] = 1'b1;
    end
    if (s >= 0) begin
      m_valid[k] = 1'b1;
      m_code[k]  = code_t'(s);
    end else if (acc) m_valid[k] = 1'b0;
    m_pend[k] = np;
    m_drop[k] = d;
  endtask

  task automatic cmp(input int k, input logic v, input code_t c, input req_t oh,
                     input req_t p, input logic d);
    string nm;
    nm = (k == 0) ? "hi" : "lo";
    chk({nm, " valid"}, v, m_valid[k]);
    chk({nm, " onehot"}, oh, m_valid[k] ? (req_t'(1) << m_code[k]) : req_t'(0));
    chk({nm, " pend"}, p, m_pend[k]);
    chk({nm, " drop"}, d, m_drop[k]);
    if (m_valid[k]) chk({nm, " code"}, c, m_code[k]);
  endtask

  task automatic cmp_all();
    cmp(0, bus_h.out_valid, bus_h.out_code, bus_h.out_onehot, bus_h.pend, bus_h.drop);
    cmp(1, bus_l.out_valid, bus_l.out_code, bus_l.out_onehot, bus_l.pend, bus_l.drop);
  endtask

  task automatic drive(input req_t req, input logic rdy, input logic c);
    bus_h.in_req = req; bus_h.out_ready = rdy; bus_h.clr = c;
    bus_l.in_req = req; bus_l.out_ready = rdy; bus_l.clr = c;
  endtask

  // one clock: drive, advance both the DUTs and the model, compare at negedge
  task automatic cycle(input req_t req, input logic rdy, input logic c);
    drive(req, rdy, c);
    @(posedge clk);
    model_step(0, req, rdy, c);
    model_step(1, req, rdy, c);
    @(negedge clk);
    cmp_all();
  endtask

  int exp_h [4] = '{7, 5, 2, 0};
  int exp_l [4] = '{0, 2, 5, 7};

  initial begin
    drive('0, 1'b0, 1'b0);
    model_reset();
    #12;
    cmp_all();
    chk("rst code", bus_h.out_code, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single requests, loopback through the decoder function
    for (int i = 0; i < N_IN; i++) begin
      cycle(req_t'(1) << i, 1'b1, 1'b0);
      chk("t1 code", bus_h.out_code, i);
      chk("t1 loop", code2oh(bus_h.out_code), 32'(1) << i);
      chk("t1 loop lo", code2oh(bus_l.out_code), 32'(1) << i);
    end
    cycle('0, 1'b1, 1'b0);
    chk("t1 idle", bus_h.out_valid, 0);

    // multi-hot drain order
    for (int j = 0; j < 4; j++) begin
      cycle((j == 0) ? req_t'(8'hA5) : req_t'(0), 1'b1, 1'b0);
      chk("t2 code hi", bus_h.out_code, exp_h[j]);
      chk("t2 code lo", bus_l.out_code, exp_l[j]);
    end
    cycle('0, 1'b1, 1'b0);
    chk("t2 idle", bus_h.out_valid, 0);

    // backpressure
    cycle(8'h12, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) cycle('0, 1'b0, 1'b0);
    chk("t3 hold code", bus_h.out_code, 4);
    chk("t3 hold pend", bus_h.pend, 8'h02);
    cycle('0, 1'b1, 1'b0);
    chk("t3 next code", bus_h.out_code, 1);
    cycle('0, 1'b1, 1'b0);
    chk("t3 idle", bus_h.out_valid, 0);

    // collision with a stalled bit
    cycle(8'h08, 1'b0, 1'b0);
    cycle(8'h08, 1'b0, 1'b0);
    chk("t4 drop", bus_h.drop, 1);
    cycle('0, 1'b0, 1'b0);
    chk("t4 drop pulse", bus_h.drop, 0);
    cycle('0, 1'b1, 1'b0);
    chk("t4 single code", bus_h.out_valid, 0);

    // clr with a presented code and pending bits
    cycle(8'h01, 1'b0, 1'b0);
    cycle(8'hF0, 1'b0, 1'b0);
    chk("t5 pend", bus_h.pend, 8'hF0);
    cycle(8'h0F, 1'b1, 1'b1);
    chk("t5 clr valid", bus_h.out_valid, 0);
    chk("t5 clr pend", bus_h.pend, 0);
    cycle('0, 1'b1, 1'b0);
    chk("t5 no code", bus_h.out_valid, 0);

    // async reset mid-HOLD
    cycle(8'h30, 1'b0, 1'b0);
    chk("t6 held", bus_h.out_valid, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6 rst valid", bus_h.out_valid, 0);
    chk("t6 rst onehot", bus_h.out_onehot, 0);
    chk("t6 rst code", bus_h.out_code, 0);
    chk("t6 rst pend", bus_h.pend, 0);
    drive('0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle('0, 1'b1, 1'b0);
    chk("t6 no reemit", bus_h.out_valid, 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      req_t r;
      r = ($urandom_range(0, 2) == 0) ? req_t'($urandom) : req_t'(0);
      cycle(r, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
